// File: rtl/prefetch_req_issuer.sv
// Next-line prefetch receiver: line-aligns and de-duplicates an incoming
// batch, buffers whole batches, and issues their lines one per handshake.
module prefetch_req_issuer #(
   parameter int ENTRIES     = 4,
   parameter int LINE_SIZE   = 64,
   parameter int QUEUE_DEPTH = 2,
   localparam int LANE_W     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    pf_valid,
   input  logic [ENTRIES-1:0]      pf_mask,
   input  logic [ENTRIES*32-1:0]   pf_addr,
   output logic                    pf_ready,
   output logic                    req_valid,
   output logic [31:0]             req_addr,
   output logic [LANE_W-1:0]       req_lane,
   input  logic                    req_ready,
   output logic                    busy,
   output logic [15:0]             drop_count
);

   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [31:0] LINE_MASK = ~(32'(LINE_SIZE) - 32'd1);

   // The mask stored per slot doubles as the pending mask once the slot
   // reaches the head: issued lanes are cleared in place.
   logic [ENTRIES-1:0] mask_mem [QUEUE_DEPTH];
   logic [31:0]        addr_mem [QUEUE_DEPTH][ENTRIES];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [CNT_W-1:0]   occ;

   logic [31:0]        aligned [ENTRIES];
   logic [ENTRIES-1:0] eff_mask;
   logic [ENTRIES-1:0] head_mask;
   logic [ENTRIES-1:0] sel_onehot;
   logic [ENTRIES-1:0] cleared_mask;
   logic [LANE_W-1:0]  sel_lane;
   logic               full;
   logic               push;
   logic               drop;
   logic               accept_hs;
   logic               pop;

   // Align incoming lanes and drop masked-off or duplicate-line lanes.
   always_comb begin
      aligned  = '{default: '0};
      eff_mask = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         aligned[i] = pf_addr[32*i +: 32] & LINE_MASK;
      end
      for (int i = 0; i < ENTRIES; i++) begin
         eff_mask[i] = pf_mask[i];
         for (int j = 0; j < i; j++) begin
            if (pf_mask[j] && (aligned[j] == aligned[i])) eff_mask[i] = 1'b0;
         end
      end
   end

   // Pick the lowest pending lane of the head batch and derive queue control.
   always_comb begin
      head_mask  = mask_mem[head];
      sel_lane   = '0;
      sel_onehot = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (head_mask[i]) sel_lane = LANE_W'(i);
      end
      sel_onehot[sel_lane] = 1'b1;
      cleared_mask = head_mask & ~sel_onehot;

      full      = (occ == CNT_W'(QUEUE_DEPTH));
      push      = pf_valid && (eff_mask != '0) && !full;
      drop      = pf_valid && (eff_mask != '0) && full;
      req_valid = (occ != '0);
      accept_hs = req_valid && req_ready;
      pop       = accept_hs && (cleared_mask == '0);

      pf_ready  = !full;
      busy      = req_valid;
      req_lane  = req_valid ? sel_lane : '0;
      req_addr  = req_valid ? addr_mem[head][sel_lane] : 32'd0;
   end

   // Queue pointers, occupancy, pending masks and the drop counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         occ        <= '0;
         head       <= '0;
         tail       <= '0;
         drop_count <= '0;
         for (int q = 0; q < QUEUE_DEPTH; q++) mask_mem[q] <= '0;
      end else begin
         // head and tail only coincide when empty (no handshake) or full (no push)
         if (accept_hs) mask_mem[head] <= cleared_mask;
         if (push) begin
            mask_mem[tail] <= eff_mask;
            tail           <= tail + PTR_W'(1);
         end
         if (pop) head <= head + PTR_W'(1);
         if (push && !pop)      occ <= occ + CNT_W'(1);
         else if (pop && !push) occ <= occ - CNT_W'(1);
         if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      end
   end

   // Aligned addresses are only read through a nonzero pending mask,
   // so the storage itself needs no reset.
   always_ff @(posedge clk) begin
      if (reset && push) begin
         for (int i = 0; i < ENTRIES; i++) addr_mem[tail][i] <= aligned[i];
      end
   end

endmodule

// File: tb/tb_prefetch_req_issuer.sv
// Directed bench for prefetch_req_issuer with an expected-request scoreboard.
module tb_prefetch_req_issuer;

   logic         clk;
   logic         reset;
   logic         pf_valid;
   logic [3:0]   pf_mask;
   logic [127:0] pf_addr;
   logic         pf_ready;
   logic         req_valid;
   logic [31:0]  req_addr;
   logic [1:0]   req_lane;
   logic         req_ready;
   logic         busy;
   logic [15:0]  drop_count;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  lane;
   } req_t;

   req_t sb[$];
   int   total = 0;
   int   bad   = 0;

   prefetch_req_issuer #(.ENTRIES(4), .LINE_SIZE(64), .QUEUE_DEPTH(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .pf_valid   (pf_valid),
      .pf_mask    (pf_mask),
      .pf_addr    (pf_addr),
      .pf_ready   (pf_ready),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_lane   (req_lane),
      .req_ready  (req_ready),
      .busy       (busy),
      .drop_count (drop_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: sample at the falling edge, retire any handshake against
   // the scoreboard, then return 1 time unit after the rising edge.
   task automatic cycle(input int exp_v);
      req_t e;
      @(negedge clk);
      if (exp_v >= 0) chk("req_valid", 32'(req_valid), 32'(exp_v));
      if (req_valid === 1'b1 && req_ready === 1'b1) begin
         total++;
         assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL sb_underflow observed=%h expected=no_request", req_addr);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("req_addr", req_addr, e.addr);
            chk("req_lane", 32'(req_lane), 32'(e.lane));
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Drive one batch for one cycle; if it should be accepted, push the
   // lines the reference model expects, lowest lane first.
   task automatic send(input logic [3:0] m, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2, input logic [31:0] a3,
                       input bit accept, input int exp_v);
      logic [31:0] al [4];
      bit          keep;
      req_t        e;
      al[0] = a0 & 32'hFFFF_FFC0;
      al[1] = a1 & 32'hFFFF_FFC0;
      al[2] = a2 & 32'hFFFF_FFC0;
      al[3] = a3 & 32'hFFFF_FFC0;
      if (accept) begin
         for (int i = 0; i < 4; i++) begin
            keep = m[i];
            for (int j = 0; j < i; j++) if (m[j] && al[j] == al[i]) keep = 1'b0;
            if (keep) begin
               e.addr = al[i];
               e.lane = 2'(i);
               sb.push_back(e);
            end
         end
      end
      pf_valid = 1'b1;
      pf_mask  = m;
      pf_addr  = {a3, a2, a1, a0};
      cycle(exp_v);
      pf_valid = 1'b0;
      pf_mask  = '0;
   endtask

   initial begin
      reset     = 1'b0;
      pf_valid  = 1'b0;
      pf_mask   = '0;
      pf_addr   = '0;
      req_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_valid", 32'(req_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pf_ready", 32'(pf_ready), 32'd1);
      chk("rst_req_addr", req_addr, 32'd0);
      chk("rst_req_lane", 32'(req_lane), 32'd0);
      chk("rst_drop_count", 32'(drop_count), 32'd0);
      reset = 1'b1;
      cycle(0);

      // single batch, four distinct lines, one per cycle
      req_ready = 1'b1;
      send(4'b1111, 32'h1000, 32'h2040, 32'h3000, 32'h4080, 1'b1, 0);
      repeat (4) cycle(1);
      chk("t1_busy_after", 32'(busy), 32'd0);
      cycle(0);

      // dedup and masking collapse to one request
      send(4'b1011, 32'h1004, 32'h1030, 32'h5000, 32'h103C, 1'b1, 0);
      cycle(1);
      cycle(0);
      chk("t2_busy_after", 32'(busy), 32'd0);

      // backpressure keeps the request stable
      req_ready = 1'b0;
      send(4'b0011, 32'h100, 32'h200, 32'h0, 32'h0, 1'b1, 0);
      for (int k = 0; k < 5; k++) begin
         cycle(1);
         chk("t3_hold_addr", req_addr, 32'h100);
         chk("t3_hold_lane", 32'(req_lane), 32'd0);
      end
      req_ready = 1'b1;
      cycle(1);
      cycle(1);
      chk("t3_busy_after", 32'(busy), 32'd0);

      // overflow: third back-to-back batch is dropped
      req_ready = 1'b0;
      send(4'b0001, 32'hA000, 32'h0, 32'h0, 32'h0, 1'b1, 0);
      chk("t4_pf_ready_1", 32'(pf_ready), 32'd1);
      send(4'b0110, 32'h0, 32'hB040, 32'hB080, 32'h0, 1'b1, 1);
      chk("t4_pf_ready_2", 32'(pf_ready), 32'd0);
      send(4'b1000, 32'h0, 32'h0, 32'h0, 32'hC000, 1'b0, 1);
      chk("t4_drop_count", 32'(drop_count), 32'd1);
      send(4'b0000, 32'hD000, 32'h0, 32'h0, 32'h0, 1'b0, 1);
      chk("t4_empty_mask_nocount", 32'(drop_count), 32'd1);
      req_ready = 1'b1;
      repeat (3) cycle(1);
      cycle(0);
      chk("t4_busy_after", 32'(busy), 32'd0);
      chk("t4_pf_ready_after", 32'(pf_ready), 32'd1);

      // simultaneous pop of the last lane and enqueue of a new batch
      req_ready = 1'b0;
      send(4'b0001, 32'hD000, 32'h0, 32'h0, 32'h0, 1'b1, 0);
      req_ready = 1'b1;
      send(4'b0101, 32'hE000, 32'h0, 32'hE100, 32'h0, 1'b1, 1);
      chk("t5_busy", 32'(busy), 32'd1);
      chk("t5_pf_ready", 32'(pf_ready), 32'd1);
      cycle(1);
      cycle(1);
      cycle(0);

      // reset with two batches queued
      req_ready = 1'b0;
      send(4'b0011, 32'h8000, 32'h9000, 32'h0, 32'h0, 1'b1, 0);
      send(4'b0001, 32'hF000, 32'h0, 32'h0, 32'h0, 1'b1, 1);
      reset = 1'b0;
      cycle(1);
      reset = 1'b1;
      sb.delete();
      chk("t6_req_valid", 32'(req_valid), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_pf_ready", 32'(pf_ready), 32'd1);
      chk("t6_drop_count", 32'(drop_count), 32'd0);
      chk("t6_req_addr", req_addr, 32'd0);
      req_ready = 1'b1;
      send(4'b0010, 32'h0, 32'h7777, 32'h0, 32'h0, 1'b1, 0);
      cycle(1);
      cycle(0);
      chk("t6_busy_after", 32'(busy), 32'd0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
